// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between VGA scanout (absolute priority,
// 2-word prefetch buffer, pixel serialiser) and a valid/ready pixel writer.
module vga_fb_arbiter #(
    parameter int PIX_PER_WORD = 8,
    parameter int BPP          = 3,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int AW           = 16,
    localparam int DW          = PIX_PER_WORD * BPP
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_de,
    input  logic          i_frame_start,
    input  logic          i_wr_valid,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ready,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [BPP-1:0] o_pix,
    output logic          o_underrun
);

    localparam int WORDS = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
    localparam int PCW   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [AW:0]    WORDS_A  = (AW+1)'(WORDS);
    localparam logic [PCW-1:0] PIX_LAST = PCW'(PIX_PER_WORD - 1);

    logic [AW:0]    rd_addr_q, rd_addr_d;
    logic [1:0]     occ_q, occ_d;
    logic           inflight_q, inflight_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
    logic [DW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [BPP-1:0] pix_q, pix_d;
    logic           underrun_q, underrun_d;
    logic           scan_req, wr_in_range, push, pop;

    function automatic logic [BPP-1:0] get_pix(input logic [DW-1:0] w, input logic [PCW-1:0] idx);
        logic [DW-1:0] sh;
        sh = w >> (idx * BPP);
        return sh[BPP-1:0];
    endfunction

    // Arbitration: scanout prefetch wins; frame start frees the slot for the writer.
    always_comb begin
        scan_req    = !i_rst && !i_frame_start &&
                      (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) &&
                      (rd_addr_q < WORDS_A);
        wr_in_range = {1'b0, i_wr_addr} < WORDS_A;
        o_wr_ready  = !scan_req && !i_rst;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (scan_req) begin
            o_mem_en   = 1'b1;
            o_mem_addr = rd_addr_q[AW-1:0];
        end else if (!i_rst && i_wr_valid && wr_in_range) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
        end
    end

    always_comb begin
        push       = inflight_q;
        pop        = i_de && (occ_q != 2'd0) && (pix_cnt_q == PIX_LAST);
        rd_addr_d  = rd_addr_q + {{AW{1'b0}}, scan_req};
        inflight_d = scan_req;
        occ_d      = occ_q;
        pix_cnt_d  = pix_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pix_d      = '0;
        underrun_d = underrun_q;
        if (i_frame_start) begin
            rd_addr_d  = '0;
            inflight_d = 1'b0;
            occ_d      = 2'd0;
            pix_cnt_d  = '0;
        end else begin
            if (i_de) begin
                if (occ_q != 2'd0) begin
                    pix_d     = get_pix(head_q, pix_cnt_q);
                    pix_cnt_d = pop ? '0 : pix_cnt_q + 1'b1;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            // Pop shifts the tail forward; the returning word lands behind what remains.
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                head_d = tail_q;
            end
            if (push) begin
                if ((occ_q - {1'b0, pop}) == 2'd0) begin
                    head_d = i_mem_rdata;
                end else begin
                    tail_d = i_mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_addr_q  <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            pix_cnt_q  <= '0;
            pix_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            pix_cnt_q  <= pix_cnt_d;
            pix_q      <= pix_d;
            underrun_q <= underrun_d;
        end
    end

    // Buffer words are qualified by occ_q, so they carry no reset.
    always_ff @(posedge i_clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign o_pix      = pix_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: small frame (64x8), behavioural RAM, frame-level pixel model.
module tb_vga_fb_arbiter;

    localparam int PPW   = 8;
    localparam int BPP   = 3;
    localparam int H     = 64;
    localparam int V     = 8;
    localparam int AW    = 16;
    localparam int DW    = PPW * BPP;
    localparam int WORDS = H * V / PPW;
    localparam int TOTAL = WORDS * PPW;

    logic clk = 1'b0;
    logic rst, de, fs, wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, rdata;
    logic wr_ready, mem_en, mem_we, underrun;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BPP-1:0] pix;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .PIX_PER_WORD(PPW), .BPP(BPP), .H_ACTIVE(H), .V_ACTIVE(V), .AW(AW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_de(de), .i_frame_start(fs),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(rdata),
        .o_pix(pix), .o_underrun(underrun)
    );

    logic [DW-1:0] ram     [WORDS];
    logic [DW-1:0] ref_mem [WORDS];
    int n_tests = 0;
    int n_fail  = 0;
    logic chk_on = 1'b0;

    function automatic logic [DW-1:0] make_word(input int w);
        logic [DW-1:0] r;
        r = '0;
        for (int p = 0; p < PPW; p++) r = r | (DW'((w + p) % 8) << (p * BPP));
        return r;
    endfunction

    function automatic logic [BPP-1:0] pix_of(input logic [DW-1:0] word, input int idx);
        logic [DW-1:0] s;
        s = word >> (idx * BPP);
        return s[BPP-1:0];
    endfunction

    function automatic logic [DW-1:0] wdat(input int n);
        return DW'(32'h00A50000 + n * 32'h1357);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-port synchronous RAM, one-cycle read latency.
    initial begin
        int ai;
        for (int w = 0; w < WORDS; w++) ram[w] = make_word(w);
        rdata = '0;
        forever begin
            @(posedge clk);
            ai = int'(mem_addr);
            if (mem_en && ai < WORDS) begin
                if (mem_we) ram[ai] = mem_wdata;
                else rdata <= ram[ai];
            end
        end
    end

    // Frame model: the k-th active cycle since frame start shows framebuffer pixel k.
    int k;
    logic [BPP-1:0] exp_pix;
    logic exp_und;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 0; exp_pix <= '0; exp_und <= 1'b0;
        end else if (fs) begin
            k <= 0; exp_pix <= '0;
        end else if (de) begin
            if (k < TOTAL) begin
                exp_pix <= pix_of(ref_mem[k / PPW], k % PPW);
                k <= k + 1;
            end else begin
                exp_pix <= '0; exp_und <= 1'b1;
            end
        end else begin
            exp_pix <= '0;
        end
    end

    initial begin
        int n, lows, errs;
        logic exp_rdy;
        for (int w = 0; w < WORDS; w++) ref_mem[w] = make_word(w);
        rst = 1'b1; de = 1'b0; fs = 1'b0;
        wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 24'h123456;
        fork
            forever begin
                @(negedge clk);
                if (chk_on && !rst) begin
                    chk("pix_model", 32'(pix), 32'(exp_pix));
                    chk("underrun_model", 32'(underrun), 32'(exp_und));
                end
            end
        join_none

        // Reset values with a write presented during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(wr_ready), 0);
        chk("rst_en", 32'(mem_en), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_pix", 32'(pix), 0);
        chk("rst_underrun", 32'(underrun), 0);

        tick();
        rst = 1'b0; wr_valid = 1'b0; chk_on = 1'b1;
        @(negedge clk);
        chk("prime0_en", 32'(mem_en), 1); chk("prime0_we", 32'(mem_we), 0);
        chk("prime0_addr", 32'(mem_addr), 0); chk("prime0_ready", 32'(wr_ready), 0);
        tick();
        @(negedge clk);
        chk("prime1_en", 32'(mem_en), 1); chk("prime1_addr", 32'(mem_addr), 1);
        tick();
        @(negedge clk);
        chk("primed_en", 32'(mem_en), 0); chk("primed_ready", 32'(wr_ready), 1);
        tick();
        tick();

        // Serialise word 0: pixels 0..7, then the pop fetches address 2.
        for (int i = 0; i < 10; i++) begin
            de = (i < 8);
            @(negedge clk);
            if (i >= 1) chk("word0_pix", 32'(pix), (i <= 8) ? 32'(i - 1) : 0);
            if (i == 8) begin
                chk("refill_en", 32'(mem_en), 1); chk("refill_we", 32'(mem_we), 0);
                chk("refill_addr", 32'(mem_addr), 2);
            end
            tick();
        end

        // Writer saturating the port during continuous active video.
        n = 0; lows = 0;
        for (int j = 0; j < 40; j++) begin
            de = 1'b1; wr_valid = 1'b1;
            wr_addr = AW'(32 + (n % 16)); wr_data = wdat(n);
            @(negedge clk);
            exp_rdy = !(j > 0 && (j % 8) == 0);
            chk("wr_ready_slot", 32'(wr_ready), 32'(exp_rdy));
            if (wr_ready) begin
                chk("wr_en", 32'(mem_en), 1); chk("wr_we", 32'(mem_we), 1);
                chk("wr_addr", 32'(mem_addr), 32'(wr_addr));
                chk("wr_wdata", 32'(mem_wdata), 32'(wr_data));
                ref_mem[int'(wr_addr)] = wr_data;
                n++;
            end else begin
                lows++;
                chk("scan_en", 32'(mem_en), 1); chk("scan_we", 32'(mem_we), 0);
                chk("scan_addr", 32'(mem_addr), 32'(j / 8 + 2));
            end
            tick();
        end
        chk("scan_slots", 32'(lows), 4);

        de = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("read7_en", 32'(mem_en), 1); chk("read7_addr", 32'(mem_addr), 7);
        tick();

        // Frame start while word 7 is returning; the writer takes the slot.
        fs = 1'b1; wr_valid = 1'b1; wr_addr = AW'(10); wr_data = 24'h5A5A5A;
        @(negedge clk);
        chk("fs_ready", 32'(wr_ready), 1); chk("fs_en", 32'(mem_en), 1);
        chk("fs_we", 32'(mem_we), 1); chk("fs_addr", 32'(mem_addr), 10);
        if (wr_ready) ref_mem[10] = wr_data;
        tick();
        fs = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("fs_read0_en", 32'(mem_en), 1); chk("fs_read0_addr", 32'(mem_addr), 0);
        tick();
        @(negedge clk);
        chk("fs_read1_en", 32'(mem_en), 1); chk("fs_read1_addr", 32'(mem_addr), 1);
        tick();
        tick();
        tick();

        // Whole frame plus three extra active cycles runs into underrun.
        for (int i = 0; i < TOTAL + 3; i++) begin
            de = 1'b1;
            @(negedge clk);
            if (i == 1) chk("first_pix", 32'(pix), 0);
            if (i == 2) chk("second_pix", 32'(pix), 1);
            tick();
        end
        de = 1'b0;
        @(negedge clk);
        chk("underrun_set", 32'(underrun), 1);
        chk("underrun_pix", 32'(pix), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("eof_ready", 32'(wr_ready), 1); chk("eof_idle", 32'(mem_en), 0);
            tick();
        end
        wr_valid = 1'b1; wr_addr = AW'(20); wr_data = 24'h0F0F0F;
        @(negedge clk);
        chk("eof_wr_en", 32'(mem_en), 1); chk("eof_wr_we", 32'(mem_we), 1);
        if (wr_ready) ref_mem[20] = wr_data;
        tick();
        wr_valid = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("underrun_sticky", 32'(underrun), 1);
        tick();

        rst = 1'b1;
        @(negedge clk);
        chk("rst2_underrun", 32'(underrun), 0);
        chk("rst2_pix", 32'(pix), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Out-of-range writes are accepted but never reach the RAM.
        wr_valid = 1'b1; wr_addr = AW'(WORDS); wr_data = 24'hFFFFFF;
        @(negedge clk);
        chk("oor_ready", 32'(wr_ready), 1); chk("oor_en", 32'(mem_en), 0);
        tick();
        wr_addr = AW'(38400);
        @(negedge clk);
        chk("oor38400_ready", 32'(wr_ready), 1); chk("oor38400_en", 32'(mem_en), 0);
        tick();
        wr_addr = AW'(WORDS - 1); wr_data = 24'h00BEEF;
        @(negedge clk);
        chk("last_ready", 32'(wr_ready), 1); chk("last_en", 32'(mem_en), 1);
        chk("last_we", 32'(mem_we), 1); chk("last_addr", 32'(mem_addr), 32'(WORDS - 1));
        if (wr_ready) ref_mem[WORDS - 1] = wr_data;
        tick();
        wr_valid = 1'b0;
        tick();
        tick();

        errs = 0;
        for (int w = 0; w < WORDS; w++) if (ram[w] !== ref_mem[w]) errs++;
        chk("ram_contents", 32'(errs), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: the VGA scanout path and a pixel writer (CPU or drawing engine).
- Scanout reads get absolute priority and are prefetched into a 2-word buffer, then serialised into one 3-bit RGB pixel per active cycle for o_red/o_grn/o_blu.
- The writer uses the remaining RAM slots through a valid/ready handshake.
- Sits between the hsync/vsync timing generators (which supply i_de and i_frame_start) and the VGA output pins.

Parameters:
- PIX_PER_WORD, 8, pixels packed per RAM word; pixel 0 occupies bits [BPP-1:0].
- BPP, 3, bits per pixel, ordered {red, green, blue}.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- AW, 16, RAM word-address width.
- Derived, not overridable: DW = PIX_PER_WORD*BPP = 24; WORDS = H_ACTIVE*V_ACTIVE/PIX_PER_WORD = 38400.

Ports:
- i_clk  in  1  25 MHz pixel clock (CLOCK_25 at top level).
- i_rst  in  1  reset, asynchronous, active-high.
- i_de  in  1  display enable, high during active pixels.
- i_frame_start  in  1  one-cycle pulse inside vblank, before the first active line.
- i_wr_valid  in  1  writer request.
- i_wr_addr  in  AW  writer word address.
- i_wr_data  in  DW  writer word data.
- o_wr_ready  out  1  writer grant this cycle.
- o_mem_en  out  1  RAM access enable.
- o_mem_we  out  1  RAM write enable.
- o_mem_addr  out  AW  RAM address.
- o_mem_wdata  out  DW  RAM write data.
- i_mem_rdata  in  DW  RAM read data, valid 1 cycle after a read.
- o_pix  out  BPP  registered pixel {r,g,b}.
- o_underrun  out  1  sticky scanout-underrun flag.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_pix=0, o_underrun=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_wr_ready=0. Internal state cleared: rd_addr=0, pix_cnt=0, buffer empty, no read in flight.
- Prefetch request:
  - scan_req = (occupancy + inflight < 2) && (rd_addr < WORDS), evaluated combinationally.
  - Occupancy is 0..2; inflight is 0..1.
- Arbitration, evaluated every cycle:
  - If scan_req: o_mem_en=1, o_mem_we=0, o_mem_addr=rd_addr; rd_addr increments and inflight is set.
  - Else if i_wr_valid: o_mem_en=1, o_mem_we=1, o_mem_addr=i_wr_addr, o_mem_wdata=i_wr_data.
  - Else o_mem_en=0.
  - o_wr_ready = !scan_req && !i_rst.
  - A write completes when i_wr_valid && o_wr_ready, in the same cycle.
  - RAM outputs are combinational from the arbitration decision.
- Out-of-range writes: if i_wr_addr >= WORDS the write is accepted (ready=1) but o_mem_en stays 0, so it is dropped.
- Read return: the cycle after a read, i_mem_rdata is pushed into the buffer and inflight clears.
- Serialiser:
  - On a cycle with i_de=1 and buffer non-empty, o_pix is loaded next edge with head[pix_cnt*BPP +: BPP]. pix_cnt increments.
  - At pix_cnt = PIX_PER_WORD-1, pix_cnt wraps to 0 and the head word pops.
  - A pop and a push in the same cycle are both allowed; occupancy is unchanged.
  - Latency: i_de to o_pix is 1 cycle. When i_de=0, o_pix loads 0 (blanking black).
- Underrun: i_de=1 with the buffer empty.
  - o_pix loads 0 and o_underrun sets.
  - pix_cnt and the buffer are untouched.
  - o_underrun clears only on i_rst.
- Frame start (i_frame_start=1) has priority over all other updates that cycle:
  - rd_addr=0, pix_cnt=0, buffer flushed.
  - A read in flight is marked discard: its returned data is dropped and inflight clears.
  - scan_req is suppressed that cycle, so the writer may be granted.
  - Priming then completes within 4 cycles.
- End of frame: after the last word is read (rd_addr == WORDS), scan_req stays 0 and the writer owns every slot until the next i_frame_start.
- Bandwidth: one word is consumed per PIX_PER_WORD active cycles, so steady-state writer throughput during active video is at least 7/8 of cycles. No underrun can occur if i_frame_start precedes active video by at least 4 cycles.
- Reset mid-operation: all state returns to reset values immediately. A write presented during reset is not accepted.

Test Plan:
- Reset release, i_de=0, no writer -> reads issued to addr 0 and 1 in the first two cycles; scan_req then 0 and o_wr_ready=1.
- RAM word 0 = 0x FAC688 (pixels 0..7 = 0,1,2,3,4,5,6,7), i_de high for 8 cycles after priming -> o_pix = 0..7 on consecutive cycles, 1 cycle after each i_de, then the pop of word 0 triggers a read of addr 2.
- Writer with i_wr_valid held high during continuous i_de -> exactly 1 of every 8 cycles has o_wr_ready=0 (scan read); all other cycles write in order; no underrun.
- i_frame_start asserted the cycle a read is issued -> returned data dropped; next reads are addr 0, 1; o_pix of the first active pixel equals word 0 pixel 0.
- i_de asserted with no i_frame_start after rd_addr == WORDS and the buffer is drained -> o_pix=0 and o_underrun=1, which stays set until i_rst.
- i_wr_addr=38400 with valid -> o_wr_ready=1, o_mem_en=0, RAM unchanged.
